// File: rtl/apb_slave_mem_pkg.sv
// Shared types and constants for the APB memory-mapped slave.
// Request fields are sized for the widest supported bus; users slice them down.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam logic APB_RESP_OKAY = 1'b0;
    localparam logic APB_RESP_ERR  = 1'b1;

    localparam int MAX_ADDR_W = 32;
    localparam int MAX_DATA_W = 64;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0]   addr;
        logic                    write;
        logic [MAX_DATA_W-1:0]   wdata;
        logic [MAX_DATA_W/8-1:0] strb;
    } apb_req_t;

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB4 completer-side bus bundle.
// Handshake: a transfer completes on the rising edge where psel, penable and pready are all high.
interface apb_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic                psel;
    logic                penable;
    logic [ADDR_W-1:0]   paddr;
    logic                pwrite;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W/8-1:0] pstrb;
    logic [DATA_W-1:0]   prdata;
    logic                pready;
    logic                pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_mem_bank.sv
// DEPTH x DATA_W storage with asynchronous clear, byte-lane writes and a combinational read port.
// The caller guarantees widx/ridx are in range when they matter.
module apb_mem_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                we,
    input  logic [IDX_W-1:0]    widx,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [IDX_W-1:0]    ridx,
    output logic [DATA_W-1:0]   rdata
);
    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0] bit_we;
    logic [DATA_W-1:0] words [DEPTH];

    for (genvar b = 0; b < LANES; b++) begin : g_lane
        assign bit_we[8*b +: 8] = {8{wstrb[b]}};
    end

    // One register per word keeps every index a constant.
    for (genvar w = 0; w < DEPTH; w++) begin : g_word
        logic [DATA_W-1:0] word_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                word_q <= '0;
            end else if (we && (widx == IDX_W'(w))) begin
                word_q <= (word_q & ~bit_we) | (wdata & bit_we);
            end
        end

        assign words[w] = word_q;
    end

    assign rdata = words[ridx];

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 memory slave: two-state transfer FSM with programmable wait states,
// address decode with PSLVERR for out-of-range, misaligned and read-only writes.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0,
    parameter int RO_WORDS    = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    apb_if.slave       bus,
    output apb_state_e state
);
    localparam int LANES  = DATA_W / 8;
    localparam int OFF_SH = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("apb_slave_mem: DATA_W must be a multiple of 8");
    end
    if (RO_WORDS > DEPTH) begin : g_bad_ro
        $error("apb_slave_mem: RO_WORDS exceeds DEPTH");
    end
    if (DEPTH * LANES > (1 << ADDR_W)) begin : g_bad_depth
        $error("apb_slave_mem: DEPTH exceeds the address space");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
        $error("apb_slave_mem: WAIT_STATES must be 0..15");
    end

    apb_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    apb_req_t   req_q, req_d;
    logic       pready;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] idx_full;
    logic              misalign;
    logic              out_of_range;
    logic              ro_hit;
    logic              err;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              unused_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        pready  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.psel && !bus.penable) begin
                    state_d     = ACCESS;
                    cnt_d       = 4'(WAIT_STATES);
                    req_d.addr  = MAX_ADDR_W'(bus.paddr);
                    req_d.write = bus.pwrite;
                    req_d.wdata = MAX_DATA_W'(bus.pwdata);
                    req_d.strb  = (MAX_DATA_W/8)'(bus.pstrb);
                end
            end
            ACCESS: begin
                // Dropping psel mid-transfer abandons it without touching memory.
                if (!bus.psel) begin
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    pready  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign addr         = req_q.addr[ADDR_W-1:0];
    assign idx_full     = addr >> OFF_SH;
    assign misalign     = (addr & ADDR_W'(LANES - 1)) != '0;
    assign out_of_range = idx_full >= ADDR_W'(DEPTH);

    if (RO_WORDS > 0) begin : g_ro
        assign ro_hit = req_q.write && (idx_full < ADDR_W'(RO_WORDS));
    end else begin : g_no_ro
        assign ro_hit = 1'b0;
    end

    assign err    = out_of_range || misalign || ro_hit;
    assign mem_we = pready && req_q.write && !err;

    apb_mem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (mem_we),
        .widx    (idx_full[IDX_W-1:0]),
        .wstrb   (req_q.strb[LANES-1:0]),
        .wdata   (req_q.wdata[DATA_W-1:0]),
        .ridx    (idx_full[IDX_W-1:0]),
        .rdata   (mem_rdata)
    );

    assign bus.pready  = pready;
    assign bus.pslverr = (pready && err) ? APB_RESP_ERR : APB_RESP_OKAY;
    assign bus.prdata  = (pready && !req_q.write && !err) ? mem_rdata : '0;
    assign state       = state_q;

    // Upper request bits exist only for the widest configuration.
    assign unused_req = ^req_q;

    a_err_needs_ready: assert property (@(posedge clk) disable iff (!reset_n)
        bus.pslverr |-> bus.pready);
    a_setup_then_enable: assert property (@(posedge clk) disable iff (!reset_n)
        (bus.psel && !bus.penable) |=> bus.penable);
    a_hold_while_waiting: assert property (@(posedge clk) disable iff (!reset_n)
        (state_q == ACCESS && !pready && bus.psel) |=> (!bus.psel || bus.penable));

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: two instances (0 and 3 wait states) driven by directed
// and random APB transfers, checked against an array model of the register bank.
module tb_apb_slave_mem;
    import apb_pkg::*;

    localparam int DEPTH    = 16;
    localparam int RO_WORDS = 2;
    localparam int MAX_LAT  = 40;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    apb_if #(.ADDR_W(10), .DATA_W(32)) bus0 ();
    apb_if #(.ADDR_W(10), .DATA_W(32)) bus1 ();

    logic        psel_v    [2];
    logic        penable_v [2];
    logic        pwrite_v  [2];
    logic [9:0]  paddr_v   [2];
    logic [31:0] pwdata_v  [2];
    logic [3:0]  pstrb_v   [2];
    logic        pready_v  [2];
    logic        pslverr_v [2];
    logic [31:0] prdata_v  [2];
    apb_state_e  state_v   [2];
    int          ws        [2] = '{0, 3};

    assign bus0.psel = psel_v[0];    assign bus1.psel = psel_v[1];
    assign bus0.penable = penable_v[0]; assign bus1.penable = penable_v[1];
    assign bus0.pwrite = pwrite_v[0];  assign bus1.pwrite = pwrite_v[1];
    assign bus0.paddr = paddr_v[0];   assign bus1.paddr = paddr_v[1];
    assign bus0.pwdata = pwdata_v[0];  assign bus1.pwdata = pwdata_v[1];
    assign bus0.pstrb = pstrb_v[0];   assign bus1.pstrb = pstrb_v[1];
    assign pready_v[0] = bus0.pready;   assign pready_v[1] = bus1.pready;
    assign pslverr_v[0] = bus0.pslverr; assign pslverr_v[1] = bus1.pslverr;
    assign prdata_v[0] = bus0.prdata;   assign prdata_v[1] = bus1.prdata;

    apb_slave_mem #(.DATA_W(32), .ADDR_W(10), .DEPTH(DEPTH), .WAIT_STATES(0), .RO_WORDS(RO_WORDS))
        u_dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0), .state(state_v[0]));
    apb_slave_mem #(.DATA_W(32), .ADDR_W(10), .DEPTH(DEPTH), .WAIT_STATES(3), .RO_WORDS(RO_WORDS))
        u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1), .state(state_v[1]));

    // Scoreboard state
    logic [31:0] model_mem [2][DEPTH];
    logic [31:0] exp_q[$];
    int n_vec = 0;
    int n_miss = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_err(input logic wr, input logic [9:0] a);
        int idx;
        idx = int'(a) / 4;
        return (idx >= DEPTH) || (int'(a) % 4 != 0) || (wr && idx < RO_WORDS);
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < DEPTH; w++) model_mem[d][w] = '0;
    endtask

    task automatic bus_idle(input int d);
        @(negedge clk);
        psel_v[d] = 1'b0;
        penable_v[d] = 1'b0;
    endtask

    // One full transfer; returns observed read data, error flag and access-cycle latency.
    task automatic apb_xfer(input int d, input logic wr, input logic [9:0] a,
                            input logic [31:0] wd, input logic [3:0] st,
                            output logic [31:0] rd, output logic er, output int lat,
                            output logic early_err);
        @(negedge clk);
        psel_v[d] = 1'b1; penable_v[d] = 1'b0; pwrite_v[d] = wr;
        paddr_v[d] = a; pwdata_v[d] = wd; pstrb_v[d] = st;
        @(negedge clk);
        penable_v[d] = 1'b1;
        lat = 1;
        early_err = 1'b0;
        #1;
        while (!pready_v[d] && lat < MAX_LAT) begin
            if (pslverr_v[d]) early_err = 1'b1;
            @(negedge clk);
            #1;
            lat++;
        end
        rd = prdata_v[d];
        er = pslverr_v[d];
        if (!pready_v[d]) check_val("pready_timeout", 0, 1);
    endtask

    task automatic do_xfer(input int d, input logic wr, input logic [9:0] a,
                           input logic [31:0] wd, input logic [3:0] st);
        logic [31:0] rd;
        logic er, early;
        logic e_err;
        int lat, idx;
        idx = int'(a) / 4;
        e_err = exp_err(wr, a);
        exp_q.push_back((wr || e_err) ? 32'h0 : model_mem[d][idx]);
        apb_xfer(d, wr, a, wd, st, rd, er, lat, early);
        check_val($sformatf("latency d%0d", d), 64'(lat), 64'(ws[d] + 1));
        check_val($sformatf("pslverr d%0d a%0h", d, a), 64'(er), 64'(e_err));
        check_val($sformatf("prdata d%0d a%0h", d, a), 64'(rd), 64'(exp_q.pop_front()));
        check_val("pslverr_without_pready", 64'(early), 64'(0));
        if (wr && !e_err)
            for (int b = 0; b < 4; b++)
                if (st[b]) model_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("%s pready d%0d", tag, d), 64'(pready_v[d]), 0);
            check_val($sformatf("%s pslverr d%0d", tag, d), 64'(pslverr_v[d]), 0);
            check_val($sformatf("%s prdata d%0d", tag, d), 64'(prdata_v[d]), 0);
            check_val($sformatf("%s state d%0d", tag, d), 64'(state_v[d]), 64'(IDLE));
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            psel_v[d] = 0; penable_v[d] = 0; pwrite_v[d] = 0;
            paddr_v[d] = '0; pwdata_v[d] = '0; pstrb_v[d] = '0;
        end
        model_clear();
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Basic write/readback on both latencies
        do_xfer(0, 1, 10'h00C, 32'hDEADBEEF, 4'hF);
        do_xfer(0, 0, 10'h00C, 32'h0, 4'h0);
        do_xfer(1, 1, 10'h01C, 32'h12345678, 4'hF);
        do_xfer(1, 0, 10'h01C, 32'h0, 4'hF);

        // Byte strobes, including the all-zero no-op
        do_xfer(0, 1, 10'h010, 32'hFFFFFFFF, 4'hF);
        do_xfer(0, 1, 10'h010, 32'h00000000, 4'h5);
        do_xfer(0, 1, 10'h010, 32'h00000000, 4'h0);
        do_xfer(0, 0, 10'h010, 32'h0, 4'h0);
        bus_idle(0);

        // Error cases: out of range, misaligned, read-only
        do_xfer(0, 0, 10'h040, 32'h0, 4'h0);
        do_xfer(0, 1, 10'h002, 32'hCAFEF00D, 4'hF);
        do_xfer(0, 1, 10'h004, 32'hCAFEF00D, 4'hF);
        do_xfer(0, 0, 10'h004, 32'h0, 4'h0);
        do_xfer(0, 0, 10'h3FC, 32'h0, 4'h0);
        do_xfer(0, 0, 10'h03C, 32'h0, 4'h0);
        bus_idle(0);

        // Abort mid-wait on the 3-wait-state instance
        do_xfer(1, 1, 10'h018, 32'hAAAA5555, 4'hF);
        @(negedge clk);
        psel_v[1] = 1; penable_v[1] = 0; pwrite_v[1] = 1;
        paddr_v[1] = 10'h018; pwdata_v[1] = 32'h0; pstrb_v[1] = 4'hF;
        @(negedge clk); penable_v[1] = 1; #1;
        check_val("abort pready c1", 64'(pready_v[1]), 0);
        @(negedge clk); #1;
        check_val("abort pready c2", 64'(pready_v[1]), 0);
        @(negedge clk); psel_v[1] = 0; penable_v[1] = 0; #1;
        check_val("abort pready c3", 64'(pready_v[1]), 0);
        repeat (4) begin
            @(negedge clk); #1;
            check_val("abort pready after", 64'(pready_v[1]), 0);
        end
        check_val("abort state", 64'(state_v[1]), 64'(IDLE));
        do_xfer(1, 0, 10'h018, 32'h0, 4'h0);
        bus_idle(1);

        // Reset during ACCESS aborts and clears memory
        @(negedge clk);
        psel_v[1] = 1; penable_v[1] = 0; pwrite_v[1] = 1;
        paddr_v[1] = 10'h014; pwdata_v[1] = 32'h55AA55AA; pstrb_v[1] = 4'hF;
        @(negedge clk); penable_v[1] = 1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        psel_v[1] = 0; penable_v[1] = 0;
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        do_xfer(0, 0, 10'h00C, 32'h0, 4'h0);
        do_xfer(1, 0, 10'h01C, 32'h0, 4'h0);
        do_xfer(1, 0, 10'h014, 32'h0, 4'h0);
        bus_idle(0);
        bus_idle(1);

        // Random traffic, back-to-back and with idle gaps
        for (int n = 0; n < 300; n++) begin
            int d;
            logic [9:0] a;
            d = int'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) a = 10'($urandom_range(0, 10'h4F));
            else a = 10'($urandom_range(0, DEPTH - 1) * 4);
            do_xfer(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0) bus_idle(d);
        end
        bus_idle(0);
        bus_idle(1);

        // Final sweep of every word on both instances
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < DEPTH; w++) do_xfer(d, 0, 10'(w * 4), 32'h0, 4'h0);
        bus_idle(0);
        bus_idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
